// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: parity-mode codes, TX state encoding, clog2 helper.
// Declarations only; no latency or flow control of its own.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered pointers/count and combinational head read.
// Push is ignored when full, pop is ignored when empty; storage is not reset.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 16,
    localparam int PtrW = clog2(Depth),
    localparam int CntW = clog2(Depth) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full_o     = (count_q == CntW'(Depth));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even if a pop frees a slot in the same cycle.
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter; start bit falls 2 edges after a write to an idle block.
// Writes while full are dropped with a one-cycle overflow pulse; frames run back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int DataBits     = 8,
    parameter int ParityMode   = 0,
    parameter int StopBits     = 1,
    parameter int FifoDepth    = 16,
    localparam int CntW        = clog2(FifoDepth) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                TxD_start,
    input  logic [DataBits-1:0] TxD_data,
    output logic                TxD,
    output logic                TxD_busy,
    output logic                TxD_full,
    output logic                TxD_overflow,
    output logic [CntW-1:0]     TxD_count
);

    localparam int BitClks  = (ClkFrequency + Baud / 2) / Baud;
    localparam int StopClks = StopBits * BitClks;
    localparam int TickW    = clog2(StopClks);
    localparam int IdxW     = clog2(DataBits);

    localparam logic [TickW-1:0] BitReload  = TickW'(BitClks - 1);
    localparam logic [TickW-1:0] StopReload = TickW'(StopClks - 1);
    localparam logic [IdxW-1:0]  LastIdx    = IdxW'(DataBits - 1);

    if (DataBits < 5 || DataBits > 9 ||
        ParityMode < PARITY_NONE || ParityMode > PARITY_ODD ||
        !(StopBits == 1 || StopBits == 2) ||
        FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0 ||
        ClkFrequency / Baud < 2) begin : g_param_check
        $error("uart_tx_fifo: illegal parameter combination");
    end

    tx_state_e           state_q, state_d;
    logic [DataBits-1:0] shreg_q, shreg_d;
    logic                parity_q, parity_d;
    logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
    logic [TickW-1:0]    tick_q, tick_d;
    logic                txd_q, txd_d;
    logic                ovf_q;
    logic                tick_done;

    logic                fifo_pop;
    logic [DataBits-1:0] fifo_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CntW-1:0]     fifo_count;

    uart_sync_fifo #(
        .Width (DataBits),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (TxD_start),
        .push_data_i (TxD_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign tick_done = (tick_q == '0);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        tick_d    = tick_done ? BitReload : tick_q - TickW'(1);
        fifo_pop  = 1'b0;
        txd_d     = 1'b1;

        unique case (state_q)
            IDLE: begin
                tick_d = BitReload;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_data;
                    parity_d = (ParityMode == PARITY_EVEN) ? ^fifo_data : ~^fifo_data;
                    state_d  = START;
                end
            end
            START: begin
                if (tick_done) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick_done) begin
                    if (bit_idx_q == LastIdx) begin
                        bit_idx_d = '0;
                        if (ParityMode != PARITY_NONE) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                            tick_d  = StopReload;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick_done) begin
                    state_d = STOP;
                    tick_d  = StopReload;
                end
            end
            STOP: begin
                // Popping here lets the next start bit follow the last stop cycle directly.
                if (tick_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_data;
                        parity_d = (ParityMode == PARITY_EVEN) ? ^fifo_data : ~^fifo_data;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line register follows the state register, so each bit lags its state by one edge.
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_q[0];
            PARITY:  txd_d = parity_q;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
            tick_q    <= BitReload;
            txd_q     <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
            tick_q    <= tick_d;
            txd_q     <= txd_d;
            ovf_q     <= TxD_start && fifo_full;
        end
    end

    assign TxD          = txd_q;
    assign TxD_busy     = (state_q != IDLE) || !fifo_empty;
    assign TxD_full     = fifo_full;
    assign TxD_overflow = ovf_q;
    assign TxD_count    = fifo_count;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ClkFrequency, 50000000: clk frequency in Hz.
- Baud, 115200: line bit rate.
- DataBits, 8: data bits per frame, legal range 5..9.
- ParityMode, 0: 0 none, 1 even, 2 odd.
- StopBits, 1: stop bits per frame, 1 or 2.
- FifoDepth, 16: TX FIFO entries, power of 2, at least 2.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock.
- rst, in, 1: reset, asynchronous and active-high.
- TxD_start, in, 1: write strobe, pushes TxD_data into the FIFO.
- TxD_data, in, DataBits: word to send, LSB first.
- TxD, out, 1: serial line, idle high.
- TxD_busy, out, 1: high when a frame is in progress or the FIFO is non-empty.
- TxD_full, out, 1: FIFO full.
- TxD_overflow, out, 1: one-cycle pulse when a write is dropped.
- TxD_count, out, clog2(FifoDepth)+1: current FIFO occupancy.

REQ-003 Elaboration SHALL fail if any of the following hold: DataBits outside 5..9, ParityMode greater than 2, StopBits not 1 or 2, FifoDepth not a power of 2, or ClkFrequency/Baud less than 2.

Function
REQ-004 BitClks SHALL equal round(ClkFrequency/Baud); every line bit, including start, data, parity and stop, SHALL last exactly BitClks cycles.
REQ-005 A write with TxD_start=1 and TxD_full=0 SHALL store TxD_data at the tail of the FIFO on that clk edge.
REQ-006 A write with TxD_start=1 and TxD_full=1 SHALL be dropped, leave the FIFO unchanged, and pulse TxD_overflow for exactly one cycle. This holds even if the transmitter pops in the same cycle.
REQ-007 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-008 In IDLE with the FIFO non-empty, the block SHALL pop the head word into a shift register and enter START on the next edge.
REQ-009 START SHALL drive TxD=0, then move to DATA.
REQ-010 DATA SHALL shift out DataBits bits LSB first, using a bit counter that runs 0..DataBits-1.
REQ-011 After DATA, the block SHALL go to PARITY if ParityMode is not 0, otherwise to STOP.
REQ-012 PARITY SHALL drive the XOR of all data bits for even parity, and its inverse for odd parity.
REQ-013 STOP SHALL drive TxD=1 for StopBits*BitClks cycles.
REQ-014 At the end of STOP, the block SHALL pop and re-enter START on the next edge if the FIFO is non-empty, giving back-to-back frames with no idle gap; otherwise it SHALL return to IDLE.
REQ-015 TxD SHALL be a registered output.
REQ-016 With an idle, empty block, the falling edge of the start bit SHALL appear 2 clk edges after the edge that accepted the write.
REQ-017 The bit-time counter SHALL reload on every state or bit change, and SHALL NOT free-run between frames.
REQ-018 A simultaneous push and pop SHALL leave TxD_count unchanged.
REQ-019 Write and read pointers SHALL wrap modulo FifoDepth.
REQ-020 TxD_full SHALL equal (TxD_count==FifoDepth).
REQ-021 TxD_busy SHALL equal (state!=IDLE) OR (TxD_count!=0).

Reset
REQ-022 Asserting rst SHALL immediately force TxD=1, state IDLE, TxD_count=0, both FIFO pointers 0, TxD_overflow=0, TxD_busy=0 and TxD_full=0.
REQ-023 A frame in progress when rst asserts SHALL be abandoned, and its queued words SHALL be discarded.
REQ-024 The first write accepted after rst deasserts SHALL obey REQ-016.
REQ-025 FIFO storage contents SHALL NOT require reset.

Structure
REQ-026 The shared package uart_pkg SHALL hold the following:
- the parity-mode constants PARITY_NONE, PARITY_EVEN and PARITY_ODD;
- the TX state enum;
- a clog2 helper function.
REQ-027 The FIFO SHALL be a sub-module named uart_sync_fifo, parametrised by width and depth and exposing push, pop, full, empty and count.
REQ-028 The shift register, the bit-time counter and the state machine SHALL stay in uart_tx_fifo.

Verification
REQ-029 The bench SHALL cover these directed scenarios. Unless a scenario states otherwise, it uses ClkFrequency=1600, Baud=100, so BitClks=16.
- Scenario 1: DataBits=8, ParityMode=0, StopBits=1; write 0xA5 when idle. Required response: TxD falls 2 edges after the write, then shows 0,1,0,1,0,0,1,0,1,1 with each bit 16 cycles, then TxD_busy drops.
- Scenario 2: DataBits=7, ParityMode=1, StopBits=2; write 0x03. Required response: data bits 1,1,0,0,0,0,0, then parity bit 0, then high for 32 cycles.
- Scenario 3: ParityMode=2; write 0x00. Required response: the parity bit is 1.
- Scenario 4: FifoDepth=4; 5 consecutive writes 0x11..0x15 while idle. Required response: 0x11 is popped at once, 0x12..0x15 fill the FIFO so TxD_count reaches 4 and TxD_full is high, no overflow pulse occurs, and all 5 frames go out back-to-back with no high gap beyond the stop bits.
- Scenario 5: FifoDepth=4; 6 consecutive writes 0x11..0x16. Required response: the 6th write pulses TxD_overflow once and 0x16 is never transmitted.
- Scenario 6: Write 0xFF, then 0x0F; assert rst during data bit 3 of the first frame. Required response: TxD goes to 1 with no clock edge, TxD_count=0, and no further frame is sent after rst deasserts.
